// File: rtl/addr_decode_pkg.sv
// Shared types and reset-time contents of the address window table.
// Widths are the maxima any instance may use; the decoder truncates them.
package addr_decode_pkg;

  localparam int ADDR_MAX_W = 64;
  localparam int WAIT_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] base;
    logic [ADDR_MAX_W-1:0] mask;
    logic [WAIT_MAX_W-1:0] wait_cnt;
    logic                  enable;
  } region_entry_t;

  localparam region_entry_t ROM_ENTRY  = '{base: 64'h0000_0000, mask: 64'hFFFF_8000,
                                           wait_cnt: 16'd0, enable: 1'b1};
  localparam region_entry_t IO_ENTRY   = '{base: 64'h0040_0000, mask: 64'hFFFF_0000,
                                           wait_cnt: 16'd1, enable: 1'b1};
  localparam region_entry_t DRAM_ENTRY = '{base: 64'h0800_0000, mask: 64'hFC00_0000,
                                           wait_cnt: 16'd2, enable: 1'b1};
  localparam region_entry_t SRAM_ENTRY = '{base: 64'hF000_0000, mask: 64'hFFFC_0000,
                                           wait_cnt: 16'd0, enable: 1'b1};

  function automatic region_entry_t default_entry(input int idx);
    case (idx)
      0:       return ROM_ENTRY;
      1:       return IO_ENTRY;
      2:       return DRAM_ENTRY;
      3:       return SRAM_ENTRY;
      default: return '0;
    endcase
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] dflt_base(input int idx);
    region_entry_t e;
    e = default_entry(idx);
    return e.base;
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] dflt_mask(input int idx);
    region_entry_t e;
    e = default_entry(idx);
    return e.mask;
  endfunction

  function automatic logic [WAIT_MAX_W-1:0] dflt_wait(input int idx);
    region_entry_t e;
    e = default_entry(idx);
    return e.wait_cnt;
  endfunction

  function automatic logic dflt_enable(input int idx);
    region_entry_t e;
    e = default_entry(idx);
    return e.enable;
  endfunction

endpackage

// File: rtl/addr_region_match.sv
// Single decode-window comparator: hit when enabled and masked address equals masked base.
module addr_region_match
  import addr_decode_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic              enable,
  output logic              hit
);

  assign hit = enable && ((addr & mask) == (base & mask));

endmodule

// File: rtl/addr_window_decoder.sv
// CPU address window decoder: programmable region table, priority select,
// wait-state counting and DTACK/BERR handshake with registered outputs.
module addr_window_decoder
  import addr_decode_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 32,
  parameter int WAIT_W      = 4,
  localparam int IDX_W      = $clog2(NUM_REGIONS)
) (
  input  logic                   Clock,
  input  logic                   Reset_H,
  input  logic [ADDR_W-1:0]      Address,
  input  logic                   AS_L,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   Dtack_L,
  output logic                   BusError_L,
  input  logic                   CfgWrite_H,
  input  logic [IDX_W-1:0]       CfgIndex,
  input  logic [ADDR_W-1:0]      CfgBase,
  input  logic [ADDR_W-1:0]      CfgMask,
  input  logic [WAIT_W-1:0]      CfgWait,
  input  logic                   CfgEnable
);

  logic [NUM_REGIONS-1:0][ADDR_W-1:0] base_q;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0] mask_q;
  logic [NUM_REGIONS-1:0][WAIT_W-1:0] wait_q;
  logic [NUM_REGIONS-1:0]             en_q;

  logic                   cfg_ok;
  assign cfg_ok = CfgWrite_H && (32'(CfgIndex) < 32'(NUM_REGIONS));

  // Writes land at the edge, so a decode on the same edge still sees the old entry.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i] <= ADDR_W'(dflt_base(i));
        mask_q[i] <= ADDR_W'(dflt_mask(i));
        wait_q[i] <= WAIT_W'(dflt_wait(i));
        en_q[i]   <= dflt_enable(i);
      end
    end else if (cfg_ok) begin
      base_q[CfgIndex] <= CfgBase;
      mask_q[CfgIndex] <= CfgMask;
      wait_q[CfgIndex] <= CfgWait;
      en_q[CfgIndex]   <= CfgEnable;
    end
  end

  logic [NUM_REGIONS-1:0] hit;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    addr_region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr   (Address),
      .base   (base_q[g]),
      .mask   (mask_q[g]),
      .enable (en_q[g]),
      .hit    (hit[g])
    );
  end

  logic             any_hit;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  state_t                 state, state_n;
  logic [WAIT_W-1:0]      cnt, cnt_n;
  logic [NUM_REGIONS-1:0] sel_q, sel_n;
  logic                   dtack_q, dtack_n;
  logic                   berr_q, berr_n;

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sel_q   <= sel_n;
      dtack_q <= dtack_n;
      berr_q  <= berr_n;
    end
  end

  // Leaving IDLE only ever happens on AS_L low, and returning only on AS_L high,
  // so a strobe held low never re-decodes without first being seen high.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    dtack_n = dtack_q;
    berr_n  = berr_q;
    case (state)
      ST_IDLE: begin
        if (!AS_L) begin
          if (any_hit) begin
            sel_n          = '0;
            sel_n[win_idx] = 1'b1;
            cnt_n          = wait_q[win_idx];
            state_n        = ST_WAIT;
          end else begin
            berr_n  = 1'b0;
            state_n = ST_BERR;
          end
        end
      end
      ST_WAIT: begin
        if (AS_L) begin
          sel_n   = '0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          dtack_n = 1'b0;
          state_n = ST_ACK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_ACK, ST_BERR: begin
        if (AS_L) begin
          sel_n   = '0;
          dtack_n = 1'b1;
          berr_n  = 1'b1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        sel_n   = '0;
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign Select_H   = sel_q;
  assign Dtack_L    = dtack_q;
  assign BusError_L = berr_q;

endmodule
